// File: rtl/ext_mem_arb.sv
// ext_mem_arb: external memory bus arbiter for the Z80 core, the LCD
// fetch engine and the loader. Grants are issued only on mem_ena slot
// strobes. Each access lasts WAIT_STATES+1 slots and is followed by at
// least one slot with every strobe high.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_ena                    one-clock memory slot strobe
//   *_req / *_we / *_addr      requests (held until ack), write flag, address
//   *_wdata                    write data (Z80, loader)
//   *_ack                      one-clock completion pulse per requester
//   rdata                      read data, valid from ack, held to next completion
//   ext_*                      external bus: strobes/selects active low
//   busy, owner                access in progress / current owner
//
// state  | meaning
// IDLE   | no access; grant on mem_ena when any request is pending
// ACCESS | bus driven for the granted requester until the final slot
module ext_mem_arb #(
    parameter int WAIT_STATES  = 1,
    parameter int LCD_MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ena,
    input  logic        z80_req,
    input  logic        lcd_req,
    input  logic        ldr_req,
    input  logic        z80_we,
    input  logic        ldr_we,
    input  logic [21:0] z80_addr,
    input  logic [21:0] lcd_addr,
    input  logic [21:0] ldr_addr,
    input  logic [7:0]  z80_wdata,
    input  logic [7:0]  ldr_wdata,
    output logic        z80_ack,
    output logic        lcd_ack,
    output logic        ldr_ack,
    output logic [7:0]  rdata,
    output logic        ext_oe_n,
    output logic        ext_we_n,
    output logic        rom_cs_n,
    output logic        ram_cs_n,
    output logic [3:1]  ext_cs_n,
    output logic [21:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        busy,
    output logic [1:0]  owner
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_Z80  = 2'b01;
    localparam logic [1:0] OWN_LCD  = 2'b10;
    localparam logic [1:0] OWN_LDR  = 2'b11;

    localparam int WCW = (WAIT_STATES  > 0) ? $clog2(WAIT_STATES + 1)  : 1;
    localparam int SCW = (LCD_MAX_WAIT > 0) ? $clog2(LCD_MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_INIT  = WCW'(WAIT_STATES);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(LCD_MAX_WAIT);

    state_t          state, state_nxt;
    logic [WCW-1:0]  wait_cnt, wait_cnt_nxt;
    logic [SCW-1:0]  lcd_starve, lcd_starve_nxt;
    logic            rr_lcd, rr_lcd_nxt;   // 1: LCD wins an LCD/loader tie
    logic            we_q, we_q_nxt;

    logic        z80_ack_nxt, lcd_ack_nxt, ldr_ack_nxt;
    logic [7:0]  rdata_nxt;
    logic        ext_oe_n_nxt, ext_we_n_nxt, rom_cs_n_nxt, ram_cs_n_nxt;
    logic [3:1]  ext_cs_n_nxt;
    logic [21:0] ext_addr_nxt;
    logic [7:0]  ext_wdata_nxt;
    logic        busy_nxt;
    logic [1:0]  owner_nxt;

    logic [1:0]  gnt;
    logic [21:0] g_addr;
    logic        g_we;
    logic [7:0]  g_wdata;
    logic        g_rom;

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        lcd_starve_nxt = lcd_starve;
        rr_lcd_nxt     = rr_lcd;
        we_q_nxt       = we_q;
        z80_ack_nxt    = 1'b0;
        lcd_ack_nxt    = 1'b0;
        ldr_ack_nxt    = 1'b0;
        rdata_nxt      = rdata;
        ext_oe_n_nxt   = ext_oe_n;
        ext_we_n_nxt   = ext_we_n;
        rom_cs_n_nxt   = rom_cs_n;
        ram_cs_n_nxt   = ram_cs_n;
        ext_cs_n_nxt   = ext_cs_n;
        ext_addr_nxt   = ext_addr;
        ext_wdata_nxt  = ext_wdata;
        busy_nxt       = busy;
        owner_nxt      = owner;

        // LCD overrides Z80 once starved; otherwise Z80, then LCD/loader round-robin
        if (lcd_req && (lcd_starve == STARVE_MAX))
            gnt = OWN_LCD;
        else if (z80_req)
            gnt = OWN_Z80;
        else if (lcd_req && (!ldr_req || rr_lcd))
            gnt = OWN_LCD;
        else
            gnt = OWN_LDR;

        case (gnt)
            OWN_Z80: begin g_addr = z80_addr; g_we = z80_we; g_wdata = z80_wdata; end
            OWN_LCD: begin g_addr = lcd_addr; g_we = 1'b0;   g_wdata = 8'h00;     end
            default: begin g_addr = ldr_addr; g_we = ldr_we; g_wdata = ldr_wdata; end
        endcase
        g_rom = (g_addr[21:19] == 3'b000);

        case (state)
            IDLE: begin
                if (mem_ena && (z80_req || lcd_req || ldr_req)) begin
                    state_nxt     = ACCESS;
                    wait_cnt_nxt  = WAIT_INIT;
                    we_q_nxt      = g_we;
                    busy_nxt      = 1'b1;
                    owner_nxt     = gnt;
                    ext_addr_nxt  = g_addr;
                    ext_wdata_nxt = g_wdata;
                    ext_oe_n_nxt  = g_we;
                    ext_we_n_nxt  = !(g_we && !g_rom);   // ROM is never write-strobed
                    rom_cs_n_nxt  = !g_rom;
                    ram_cs_n_nxt  = !(g_addr[21:19] == 3'b001);
                    ext_cs_n_nxt  = {!(g_addr[21:20] == 2'b11),
                                     !(g_addr[21:20] == 2'b10),
                                     !(g_addr[21:20] == 2'b01)};
                    if (gnt == OWN_LCD) begin
                        lcd_starve_nxt = '0;
                        rr_lcd_nxt     = 1'b0;
                    end else if (gnt == OWN_LDR) begin
                        rr_lcd_nxt = 1'b1;
                    end else if (lcd_req && (lcd_starve != STARVE_MAX)) begin
                        lcd_starve_nxt = lcd_starve + SCW'(1);
                    end
                end
            end
            ACCESS: begin
                if (mem_ena) begin
                    if (wait_cnt == '0) begin
                        state_nxt    = IDLE;
                        if (!we_q)
                            rdata_nxt = ext_rdata;
                        z80_ack_nxt  = (owner == OWN_Z80);
                        lcd_ack_nxt  = (owner == OWN_LCD);
                        ldr_ack_nxt  = (owner == OWN_LDR);
                        ext_oe_n_nxt = 1'b1;
                        ext_we_n_nxt = 1'b1;
                        rom_cs_n_nxt = 1'b1;
                        ram_cs_n_nxt = 1'b1;
                        ext_cs_n_nxt = 3'b111;
                        busy_nxt     = 1'b0;
                        owner_nxt    = OWN_NONE;
                    end else begin
                        wait_cnt_nxt = wait_cnt - WCW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lcd_starve <= '0;
            rr_lcd     <= 1'b1;
            we_q       <= 1'b0;
            z80_ack    <= 1'b0;
            lcd_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            rdata      <= 8'h00;
            ext_oe_n   <= 1'b1;
            ext_we_n   <= 1'b1;
            rom_cs_n   <= 1'b1;
            ram_cs_n   <= 1'b1;
            ext_cs_n   <= 3'b111;
            ext_addr   <= '0;
            ext_wdata  <= 8'h00;
            busy       <= 1'b0;
            owner      <= OWN_NONE;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            lcd_starve <= lcd_starve_nxt;
            rr_lcd     <= rr_lcd_nxt;
            we_q       <= we_q_nxt;
            z80_ack    <= z80_ack_nxt;
            lcd_ack    <= lcd_ack_nxt;
            ldr_ack    <= ldr_ack_nxt;
            rdata      <= rdata_nxt;
            ext_oe_n   <= ext_oe_n_nxt;
            ext_we_n   <= ext_we_n_nxt;
            rom_cs_n   <= rom_cs_n_nxt;
            ram_cs_n   <= ram_cs_n_nxt;
            ext_cs_n   <= ext_cs_n_nxt;
            ext_addr   <= ext_addr_nxt;
            ext_wdata  <= ext_wdata_nxt;
            busy       <= busy_nxt;
            owner      <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_ext_mem_arb.sv
module tb_ext_mem_arb;

    localparam int WS = 1;

    logic        clk, rst, mem_ena;
    logic        z80_req, lcd_req, ldr_req, z80_we, ldr_we;
    logic [21:0] z80_addr, lcd_addr, ldr_addr;
    logic [7:0]  z80_wdata, ldr_wdata;
    logic        z80_ack, lcd_ack, ldr_ack;
    logic [7:0]  rdata;
    logic        ext_oe_n, ext_we_n, rom_cs_n, ram_cs_n;
    logic [3:1]  ext_cs_n;
    logic [21:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic        busy;
    logic [1:0]  owner;

    ext_mem_arb #(.WAIT_STATES(WS), .LCD_MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst), .mem_ena(mem_ena),
        .z80_req(z80_req), .lcd_req(lcd_req), .ldr_req(ldr_req),
        .z80_we(z80_we), .ldr_we(ldr_we),
        .z80_addr(z80_addr), .lcd_addr(lcd_addr), .ldr_addr(ldr_addr),
        .z80_wdata(z80_wdata), .ldr_wdata(ldr_wdata),
        .z80_ack(z80_ack), .lcd_ack(lcd_ack), .ldr_ack(ldr_ack),
        .rdata(rdata),
        .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n),
        .rom_cs_n(rom_cs_n), .ram_cs_n(ram_cs_n), .ext_cs_n(ext_cs_n),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic [1:0]  owner;
        logic [21:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   acks_seen = 0;
    bit   mon_en = 0;
    bit   have_cur = 0;
    bit   prev_busy = 0;
    int   ticks = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // memory slot strobe: one clock in five
    initial begin
        mem_ena = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            mem_ena = 1'b1;
            @(negedge clk);
            mem_ena = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] o, input logic [21:0] a, input logic w,
                            input logic [7:0] wd, input logic [7:0] rd);
        exp_t e;
        e.owner = o; e.addr = a; e.we = w; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // expected selects, ordered {rom, ram, cs3, cs2, cs1}, active low
    function automatic logic [4:0] exp_sel(input logic [21:0] a);
        logic [4:0] s;
        s = 5'b11111;
        case (a[21:20])
            2'b00:   if (a[19]) s[3] = 1'b0; else s[4] = 1'b0;
            2'b01:   s[0] = 1'b0;
            2'b10:   s[1] = 1'b0;
            default: s[2] = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] exp_ack(input logic [1:0] o);
        return (o == 2'd1) ? 3'b100 : (o == 2'd2) ? 3'b010 : (o == 2'd3) ? 3'b001 : 3'b000;
    endfunction

    // monitor: pop expectation on each grant, finish it on the ack
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (rst) begin
                    have_cur  = 0;
                    prev_busy = 0;
                    ticks     = 0;
                end else begin
                    if (busy === 1'b1 && !prev_busy) begin
                        if (exp_q.size() == 0) begin
                            tests++; fails++;
                            $error("FAIL unexpected_grant observed owner=%0d expected none", owner);
                        end else begin
                            cur = exp_q.pop_front();
                            have_cur = 1;
                            ticks = 0;
                            check("grant_owner", 32'(owner), 32'(cur.owner));
                            check("grant_addr", 32'(ext_addr), 32'(cur.addr));
                            check("grant_sel", 32'({rom_cs_n, ram_cs_n, ext_cs_n[3], ext_cs_n[2], ext_cs_n[1]}),
                                  32'(exp_sel(cur.addr)));
                            check("grant_oe_n", 32'(ext_oe_n), 32'(cur.we));
                            check("grant_we_n", 32'(ext_we_n),
                                  32'(!(cur.we && (cur.addr[21:19] != 3'b000))));
                            if (cur.we)
                                check("grant_wdata", 32'(ext_wdata), 32'(cur.wdata));
                        end
                    end else if (prev_busy && mem_ena) begin
                        ticks++;
                    end
                    if (z80_ack || lcd_ack || ldr_ack) begin
                        acks_seen++;
                        if (!have_cur) begin
                            tests++; fails++;
                            $error("FAIL unexpected_ack observed=%b expected none", {z80_ack, lcd_ack, ldr_ack});
                        end else begin
                            check("ack_who", 32'({z80_ack, lcd_ack, ldr_ack}), 32'(exp_ack(cur.owner)));
                            check("ack_ticks", 32'(ticks), 32'(WS + 1));
                            check("ack_idle_strobes",
                                  32'({ext_oe_n, ext_we_n, rom_cs_n, ram_cs_n, ext_cs_n, busy, owner}),
                                  32'({7'h7F, 1'b0, 2'b00}));
                            if (!cur.we)
                                check("ack_rdata", 32'(rdata), 32'(cur.rdata));
                            have_cur = 0;
                        end
                    end
                    prev_busy = (busy === 1'b1);
                end
            end
        end
    end

    task automatic wait_acks(input int n, input int budget, input string tag);
        int base;
        int c;
        base = acks_seen;
        c = 0;
        while ((acks_seen - base) < n && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        if ((acks_seen - base) < n) begin
            tests++; fails++;
            $error("FAIL %s_timeout observed acks=%0d expected=%0d", tag, acks_seen - base, n);
        end
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int c;
        c = 0;
        while (busy !== 1'b1 && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        check(tag, 32'(busy), 32'd1);
    endtask

    initial begin
        int a0;
        int c;
        rst = 1'b1;
        z80_req = 0; lcd_req = 0; ldr_req = 0; z80_we = 0; ldr_we = 0;
        z80_addr = '0; lcd_addr = '0; ldr_addr = '0;
        z80_wdata = '0; ldr_wdata = '0; ext_rdata = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_oe_we", 32'({ext_oe_n, ext_we_n}), 32'(2'b11));
        check("rst_sel", 32'({rom_cs_n, ram_cs_n, ext_cs_n}), 32'(5'b11111));
        check("rst_acks", 32'({z80_ack, lcd_ack, ldr_ack}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_addr", 32'(ext_addr), 32'd0);
        check("rst_wdata", 32'(ext_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        // Z80 read from RAM
        ext_rdata = 8'h5A;
        z80_addr = 22'h080123; z80_we = 0;
        push_exp(2'd1, 22'h080123, 1'b0, 8'h00, 8'h5A);
        @(negedge clk);
        z80_req = 1;
        wait_acks(1, 40, "z80_read");
        @(negedge clk);
        z80_req = 0;

        // loader write to ROM: no write strobe, rdata untouched
        ldr_addr = 22'h000010; ldr_we = 1; ldr_wdata = 8'hA5;
        push_exp(2'd3, 22'h000010, 1'b1, 8'hA5, 8'h00);
        @(negedge clk);
        ldr_req = 1;
        wait_acks(1, 40, "ldr_rom_write");
        @(negedge clk);
        ldr_req = 0;
        check("rdata_hold_after_write", 32'(rdata), 32'h5A);

        // Z80 and LCD held: Z80 x3 then LCD
        ext_rdata = 8'h11;
        lcd_addr = 22'h300040;
        for (int i = 0; i < 2; i++) begin
            push_exp(2'd1, 22'h080123, 1'b0, 8'h00, 8'h11);
            push_exp(2'd1, 22'h080123, 1'b0, 8'h00, 8'h11);
            push_exp(2'd1, 22'h080123, 1'b0, 8'h00, 8'h11);
            push_exp(2'd2, 22'h300040, 1'b0, 8'h00, 8'h11);
        end
        @(negedge clk);
        z80_req = 1; lcd_req = 1;
        wait_acks(8, 300, "starve");
        @(negedge clk);
        z80_req = 0; lcd_req = 0;

        // LCD/loader round-robin; requests pending across reset release
        ext_rdata = 8'h22;
        lcd_addr = 22'h180000;
        ldr_addr = 22'h200000; ldr_we = 1; ldr_wdata = 8'h77;
        for (int i = 0; i < 2; i++) begin
            push_exp(2'd2, 22'h180000, 1'b0, 8'h00, 8'h22);
            push_exp(2'd3, 22'h200000, 1'b1, 8'h77, 8'h00);
        end
        @(negedge clk);
        rst = 1; lcd_req = 1; ldr_req = 1;
        @(negedge clk);
        rst = 0;
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (!mem_ena && c < 10);
        check("first_tick_grant", 32'({busy, owner}), 32'({1'b1, 2'd2}));
        wait_acks(4, 200, "round_robin");
        @(negedge clk);
        lcd_req = 0; ldr_req = 0; ldr_we = 0;

        // reset in the middle of a write
        z80_addr = 22'h080050; z80_we = 1; z80_wdata = 8'h3C;
        push_exp(2'd1, 22'h080050, 1'b1, 8'h3C, 8'h00);
        @(negedge clk);
        z80_req = 1;
        wait_busy(20, "midrst_busy_seen");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1; z80_req = 0;
        @(posedge clk);
        #2;
        check("midrst_strobes", 32'({ext_oe_n, ext_we_n, rom_cs_n, ram_cs_n, ext_cs_n}), 32'h7F);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_owner", 32'(owner), 32'd0);
        check("midrst_acks", 32'({z80_ack, lcd_ack, ldr_ack}), 32'd0);
        @(negedge clk);
        rst = 0; z80_we = 0;
        a0 = acks_seen;
        repeat (15) @(posedge clk);
        #2;
        check("midrst_no_ack", 32'(acks_seen - a0), 32'd0);

        // Z80 drops request mid-access
        ext_rdata = 8'hC3;
        z80_addr = 22'h100000;
        push_exp(2'd1, 22'h100000, 1'b0, 8'h00, 8'hC3);
        a0 = acks_seen;
        @(negedge clk);
        z80_req = 1;
        wait_busy(20, "drop_busy_seen");
        @(negedge clk);
        z80_req = 0;
        wait_acks(1, 40, "drop_req");
        repeat (20) @(posedge clk);
        #2;
        check("drop_single_ack", 32'(acks_seen - a0), 32'd1);
        check("drop_rdata_hold", 32'(rdata), 32'hC3);
        check("drop_idle", 32'({busy, owner}), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
